conv_window_ctrl: RTL

//  Sequencer that drives a conv layer's line-buffer chain (variable_shift_reg instances) from a raster pixel stream.

---
 rtl/lenet_pkg.sv | 24 ++
 rtl/axis_pos_counter.sv | 75 +++++++
 rtl/conv_window_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet conv-layer constants, feature-map geometry helpers and the window
// sequencer state type.
package lenet_pkg;

    localparam int unsigned C1_IMG_W = 28;
    localparam int unsigned C1_IMG_H = 28;
    localparam int unsigned C1_K     = 5;
    localparam int unsigned C3_IMG_W = 12;
    localparam int unsigned C3_IMG_H = 12;
    localparam int unsigned C3_K     = 5;

    typedef enum logic {StRun, StClear} win_state_e;

    function automatic int unsigned out_dim(input int unsigned img, input int unsigned k,
                                            input int unsigned stride);
        return (img - k) / stride + 1;
    endfunction

    // Index width for a counter of n values, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_pos_counter.sv
// One raster axis: pixel position, stride phase within the window grid and the
// output-map index of the window whose last pixel sits at the current position.
module axis_pos_counter
    import lenet_pkg::*;
#(
    parameter int unsigned  SIZE   = 28,
    parameter int unsigned  K      = 5,
    parameter int unsigned  STRIDE = 1,
    localparam int unsigned OUT_N  = out_dim(SIZE, K, STRIDE),
    localparam int unsigned PW     = idx_width(SIZE),
    localparam int unsigned SW     = idx_width(STRIDE),
    localparam int unsigned IW     = idx_width(OUT_N)
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic          o_last,
    output logic          o_hit,
    output logic [IW-1:0] o_idx
);

    localparam logic [PW-1:0] PosLast = PW'(SIZE - 1);
    localparam logic [PW-1:0] PosWin  = PW'(K - 1);
    localparam logic [SW-1:0] PhLast  = SW'(STRIDE - 1);

    logic [PW-1:0] pos_q, pos_d;
    logic [SW-1:0] ph_q, ph_d;
    logic [IW-1:0] idx_q, idx_d;

    always_comb begin
        pos_d = pos_q;
        ph_d  = ph_q;
        idx_d = idx_q;
        if (i_clr) begin
            pos_d = '0;
            ph_d  = '0;
            idx_d = '0;
        end else if (i_adv) begin
            if (pos_q == PosLast) begin
                pos_d = '0;
                ph_d  = '0;
                idx_d = '0;
            end else begin
                pos_d = pos_q + 1'b1;
                // Phase/index only move once the window has fully entered the axis.
                if (pos_q >= PosWin) begin
                    if (ph_q == PhLast) begin
                        ph_d  = '0;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        ph_d = ph_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            pos_q <= '0;
            ph_q  <= '0;
            idx_q <= '0;
        end else begin
            pos_q <= pos_d;
            ph_q  <= ph_d;
            idx_q <= idx_d;
        end
    end

    assign o_last = (pos_q == PosLast);
    assign o_hit  = (pos_q >= PosWin) && (ph_q == '0);
    assign o_idx  = idx_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer for one conv layer: shifts pixels into the buffers, clears
// them between frames and flags each cycle a complete KxK window is available.
module conv_window_ctrl
    import lenet_pkg::*;
#(
    parameter int unsigned  IMG_W  = 28,
    parameter int unsigned  IMG_H  = 28,
    parameter int unsigned  K      = 5,
    parameter int unsigned  STRIDE = 1,
    localparam int unsigned OUT_W  = out_dim(IMG_W, K, STRIDE),
    localparam int unsigned OUT_H  = out_dim(IMG_H, K, STRIDE),
    localparam int unsigned RW     = idx_width(OUT_H),
    localparam int unsigned CW     = idx_width(OUT_W)
) (
    input  logic          clk,
    input  logic          global_rst_n,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    output logic          o_ce,
    output logic          o_self_rst,
    output logic          o_win_valid,
    output logic [RW-1:0] o_out_row,
    output logic [CW-1:0] o_out_col,
    output logic          o_frame_done
);

    win_state_e    state_q, state_d;
    logic          win_valid_q, win_valid_d;
    logic [RW-1:0] out_row_q, out_row_d;
    logic [CW-1:0] out_col_q, out_col_d;

    logic          accept;
    logic          col_last, col_hit, row_last, row_hit;
    logic [CW-1:0] col_idx;
    logic [RW-1:0] row_idx;

    assign o_ready = (state_q == StRun);
    assign o_ce    = i_valid & o_ready;
    // The buffers still shift on a sync-reset cycle, but they are cleared by rst too.
    assign accept  = o_ce & ~rst;

    axis_pos_counter #(
        .SIZE  (IMG_W),
        .K     (K),
        .STRIDE(STRIDE)
    ) u_col (
        .clk         (clk),
        .global_rst_n(global_rst_n),
        .i_clr       (rst),
        .i_adv       (accept),
        .o_last      (col_last),
        .o_hit       (col_hit),
        .o_idx       (col_idx)
    );

    axis_pos_counter #(
        .SIZE  (IMG_H),
        .K     (K),
        .STRIDE(STRIDE)
    ) u_row (
        .clk         (clk),
        .global_rst_n(global_rst_n),
        .i_clr       (rst),
        .i_adv       (accept & col_last),
        .o_last      (row_last),
        .o_hit       (row_hit),
        .o_idx       (row_idx)
    );

    always_comb begin
        state_d     = state_q;
        win_valid_d = 1'b0;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        if (rst) begin
            state_d   = StRun;
            out_row_d = '0;
            out_col_d = '0;
        end else begin
            unique case (state_q)
                StRun:   if (accept && col_last && row_last) state_d = StClear;
                StClear: state_d = StRun;
            endcase
            if (accept && col_hit && row_hit) begin
                win_valid_d = 1'b1;
                out_row_d   = row_idx;
                out_col_d   = col_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q     <= StRun;
            win_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign o_win_valid  = win_valid_q;
    assign o_out_row    = out_row_q;
    assign o_out_col    = out_col_q;
    assign o_self_rst   = (state_q == StClear);
    assign o_frame_done = (state_q == StClear);

endmodule
